// File: rtl/cpu_hazard_scoreboard_if.sv
// Decode-side hazard bus: decode/execute/writeback inputs and the stall/scoreboard outputs.
interface cpu_hazard_scoreboard_if #(
    parameter int REG_COUNT   = 32,
    parameter int REG_IDX_W   = 5,
    parameter int NUM_SRC     = 2,
    parameter int STALL_CNT_W = 16
);
    logic                         decode_valid;
    logic [NUM_SRC*REG_IDX_W-1:0] decode_rs;
    logic [NUM_SRC-1:0]           decode_rs_use;
    logic [NUM_SRC-1:0]           decode_rs_early;
    logic [REG_IDX_W-1:0]         decode_rd;
    logic                         decode_long;
    logic [REG_IDX_W-1:0]         execute_rd;
    logic                         execute_wb;
    logic                         flush;
    logic                         wb_valid;
    logic [REG_IDX_W-1:0]         wb_rd;
    logic                         stall;
    logic [2:0]                   stall_reason;
    logic [REG_COUNT-1:0]         pending;
    logic [3:0]                   outstanding;
    logic [STALL_CNT_W-1:0]       stall_cycles;

    modport master (
        output decode_valid, decode_rs, decode_rs_use, decode_rs_early, decode_rd,
               decode_long, execute_rd, execute_wb, flush, wb_valid, wb_rd,
        input  stall, stall_reason, pending, outstanding, stall_cycles
    );

    modport slave (
        input  decode_valid, decode_rs, decode_rs_use, decode_rs_early, decode_rd,
               decode_long, execute_rd, execute_wb, flush, wb_valid, wb_rd,
        output stall, stall_reason, pending, outstanding, stall_cycles
    );
endinterface

// File: rtl/cpu_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight long-latency writers, checks early
// operands against execute, and drives stall, stall reason and a saturating stall counter.
module cpu_hazard_src_chk #(
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] rs,
    input  logic                 rs_use,
    input  logic                 rs_early,
    input  logic                 rs_pending,
    input  logic                 execute_wb,
    input  logic [REG_IDX_W-1:0] execute_rd,
    output logic                 raw,
    output logic                 early
);
    logic nz;
    assign nz    = (rs != '0);
    assign raw   = rs_use && nz && rs_pending;
    assign early = rs_early && nz && execute_wb && (rs == execute_rd);
endmodule

module cpu_hazard_scoreboard #(
    parameter int REG_COUNT   = 32,
    parameter int REG_IDX_W   = $clog2(REG_COUNT),
    parameter int NUM_SRC     = 2,
    parameter int MAX_OUTST   = 4,
    parameter int STALL_CNT_W = 16
) (
    input logic                    clock,
    input logic                    reset,
    cpu_hazard_scoreboard_if.slave bus
);
    localparam logic [2:0] R_NONE  = 3'd0;
    localparam logic [2:0] R_RAW   = 3'd1;
    localparam logic [2:0] R_EARLY = 3'd2;
    localparam logic [2:0] R_WAW   = 3'd3;
    localparam logic [2:0] R_FULL  = 3'd4;

    logic [REG_COUNT-1:0]   pend_q, pend_d;
    logic [3:0]             outst_q, outst_d;
    logic [STALL_CNT_W-1:0] cnt_q;
    logic [NUM_SRC-1:0]     raw_v, early_v;
    logic                   active, raw, early, waw, full, stall;
    logic                   issue, long_issue, dec;
    logic [2:0]             reason;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_IDX_W-1:0] rs_i;
        assign rs_i = bus.decode_rs[i*REG_IDX_W +: REG_IDX_W];
        cpu_hazard_src_chk #(.REG_IDX_W(REG_IDX_W)) u_chk (
            .rs         (rs_i),
            .rs_use     (bus.decode_rs_use[i]),
            .rs_early   (bus.decode_rs_early[i]),
            .rs_pending (pend_q[rs_i]),
            .execute_wb (bus.execute_wb),
            .execute_rd (bus.execute_rd),
            .raw        (raw_v[i]),
            .early      (early_v[i])
        );
    end

    // Hazards look only at registered state, so a writeback unblocks decode one cycle later.
    assign active = bus.decode_valid && !bus.flush;
    assign raw    = active && |raw_v;
    assign early  = active && |early_v;
    assign waw    = active && bus.decode_long && (bus.decode_rd != '0) && pend_q[bus.decode_rd];
    assign full   = active && bus.decode_long && (outst_q == 4'(MAX_OUTST));
    assign stall  = raw || early || waw || full;

    always_comb begin
        reason = R_NONE;
        if (raw)        reason = R_RAW;
        else if (early) reason = R_EARLY;
        else if (waw)   reason = R_WAW;
        else if (full)  reason = R_FULL;
    end

    assign issue      = bus.decode_valid && !stall && !bus.flush;
    assign long_issue = issue && bus.decode_long;
    // A stray writeback at zero outstanding is ignored rather than underflowing.
    assign dec        = bus.wb_valid && (outst_q != '0);

    always_comb begin
        pend_d = pend_q;
        if (bus.wb_valid) pend_d[bus.wb_rd] = 1'b0;
        if (long_issue && bus.decode_rd != '0) pend_d[bus.decode_rd] = 1'b1;
        pend_d[0] = 1'b0;
        outst_d = outst_q + {3'b0, long_issue} - {3'b0, dec};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q  <= '0;
            outst_q <= '0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            outst_q <= outst_d;
            if (stall && cnt_q != '1) cnt_q <= cnt_q + STALL_CNT_W'(1);
        end
    end

    assign bus.stall        = stall;
    assign bus.stall_reason = reason;
    assign bus.pending      = pend_q;
    assign bus.outstanding  = outst_q;
    assign bus.stall_cycles = cnt_q;

    a_wb_protocol: assert property (@(posedge clock) disable iff (reset)
        bus.wb_valid |-> (outst_q != '0 && pend_q[bus.wb_rd]))
        else $error("writeback with no matching in-flight producer");
endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Directed bench: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_cpu_hazard_scoreboard;
    localparam int CW = 8;

    typedef struct {
        string      name;
        logic       stall;
        logic [2:0] reason;
        logic [31:0] pend;
        logic [3:0] outst;
        logic [CW-1:0] cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 clock = ~clock;

    cpu_hazard_scoreboard_if #(.REG_COUNT(32), .REG_IDX_W(5), .NUM_SRC(2), .STALL_CNT_W(CW)) bus ();

    cpu_hazard_scoreboard #(
        .REG_COUNT(32), .REG_IDX_W(5), .NUM_SRC(2), .MAX_OUTST(4), .STALL_CNT_W(CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (bus.stall !== e.stall || bus.stall_reason !== e.reason || bus.pending !== e.pend ||
                bus.outstanding !== e.outst || bus.stall_cycles !== e.cyc) begin
                errors++;
                $display("FAIL %s: got stall=%0b reason=%0d pend=%h outst=%0d cyc=%0d, want stall=%0b reason=%0d pend=%h outst=%0d cyc=%0d",
                         e.name, bus.stall, bus.stall_reason, bus.pending, bus.outstanding, bus.stall_cycles,
                         e.stall, e.reason, e.pend, e.outst, e.cyc);
            end
        end
    end

    task automatic idle();
        bus.decode_valid    = 1'b0;
        bus.decode_rs       = '0;
        bus.decode_rs_use   = '0;
        bus.decode_rs_early = '0;
        bus.decode_rd       = '0;
        bus.decode_long     = 1'b0;
        bus.execute_rd      = '0;
        bus.execute_wb      = 1'b0;
        bus.flush           = 1'b0;
        bus.wb_valid        = 1'b0;
        bus.wb_rd           = '0;
    endtask

    task automatic long_op(input logic [4:0] rd);
        idle();
        bus.decode_valid = 1'b1;
        bus.decode_long  = 1'b1;
        bus.decode_rd    = rd;
    endtask

    task automatic wb(input logic [4:0] rd);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
    endtask

    task automatic push(input string n, input logic st, input logic [2:0] r,
                        input logic [31:0] p, input logic [3:0] o, input int c);
        exp_t e;
        e.name = n; e.stall = st; e.reason = r; e.pend = p; e.outst = o; e.cyc = CW'(c);
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        @(posedge clock); #1;
        push("reset", 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;

        // RAW on a long-latency producer, released the cycle after its writeback
        long_op(5);                      push("issue_rd5", 0, 0, 0, 0, 0); tick();
        idle(); bus.decode_valid = 1; bus.decode_rs = {5'd0, 5'd5}; bus.decode_rs_use = 2'b01;
        push("raw_a", 1, 1, 32'h20, 1, 0); tick();
        push("raw_b", 1, 1, 32'h20, 1, 1); tick();
        wb(5);
        push("raw_wb_same_cycle", 1, 1, 32'h20, 1, 2); tick();
        bus.wb_valid = 0;
        push("raw_released", 0, 0, 0, 0, 3); tick();

        // early operand against execute result, forwarded case, and flush gating
        idle(); bus.decode_valid = 1; bus.decode_rs = {5'd7, 5'd0};
        bus.decode_rs_use = 2'b10; bus.decode_rs_early = 2'b10;
        bus.execute_wb = 1; bus.execute_rd = 7;
        push("early_hit", 1, 2, 0, 0, 3); tick();
        bus.decode_rs_early = 2'b00;
        push("early_forwarded", 0, 0, 0, 0, 4); tick();
        bus.decode_rs_early = 2'b10; bus.flush = 1;
        push("flush_masks", 0, 0, 0, 0, 4); tick();

        // fill the scoreboard, then one writeback lets the fifth op issue
        long_op(1); push("fill1", 0, 0, 32'h0, 0, 4); tick();
        long_op(2); push("fill2", 0, 0, 32'h2, 1, 4); tick();
        long_op(3); push("fill3", 0, 0, 32'h6, 2, 4); tick();
        long_op(4); push("fill4", 0, 0, 32'hE, 3, 4); tick();
        long_op(6); push("full_a", 1, 4, 32'h1E, 4, 4); tick();
        wb(1);      push("full_wb", 1, 4, 32'h1E, 4, 5); tick();
        bus.wb_valid = 0;
        push("full_issue", 0, 0, 32'h1C, 3, 6); tick();
        idle(); wb(2); push("drain2", 0, 0, 32'h5C, 4, 6); tick();
        idle(); wb(3); push("drain3", 0, 0, 32'h58, 3, 6); tick();
        idle(); wb(4); push("drain4", 0, 0, 32'h50, 2, 6); tick();
        idle(); wb(6); push("drain6", 0, 0, 32'h40, 1, 6); tick();

        // WAW, then issue and writeback in one cycle keep the count unchanged
        long_op(9);  push("issue_rd9", 0, 0, 32'h0, 0, 6); tick();
        long_op(9);  push("waw", 1, 3, 32'h200, 1, 6); tick();
        long_op(10); wb(9); push("issue_and_wb", 0, 0, 32'h200, 1, 7); tick();
        long_op(11); bus.flush = 1; push("flush_long", 0, 0, 32'h400, 1, 7); tick();
        idle(); wb(10); push("drain10", 0, 0, 32'h400, 1, 7); tick();

        // register zero is never a hazard and never pending
        idle(); bus.decode_valid = 1; bus.decode_rs_use = 2'b11; bus.decode_rs_early = 2'b11;
        bus.execute_wb = 1; bus.execute_rd = 0;
        push("r0_sources", 0, 0, 0, 0, 7); tick();
        long_op(0); push("issue_rd0", 0, 0, 0, 0, 7); tick();
        idle();     push("rd0_counted", 0, 0, 0, 1, 7); tick();

        reset = 1'b1; push("reset_clears", 0, 0, 0, 0, 0); tick();
        reset = 1'b0;

        // long stall to saturate the counter, then async reset mid-stall
        long_op(5); push("sat_issue", 0, 0, 0, 0, 0); tick();
        idle(); bus.decode_valid = 1; bus.decode_rs = {5'd0, 5'd5}; bus.decode_rs_use = 2'b01;
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            push("sat_stall", 1, 1, 32'h20, 1, (k > (1 << CW) - 1) ? (1 << CW) - 1 : k);
            tick();
        end
        #1 reset = 1'b1;
        push("reset_mid_stall", 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        idle(); push("after_reset", 0, 0, 0, 0, 0); tick();

        for (int w = 0; w < 8 && q.size() > 0; w++) @(negedge clock);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
